// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
package clk_div_pkg;

  localparam int DIV_W_DEF  = 25;
  localparam int CLK_HZ_DEF = 27_000_000;
  // Smallest divisor that still yields a low and a high phase.
  localparam int MIN_DIV    = 2;

  // Divisor giving f_out from clk_hz, rounded to nearest; a non-positive
  // target falls back to a divide-by-clk_hz (1 Hz) setting.
  function automatic int hz2div(input int clk_hz, input int f_out);
    if (f_out <= 0) begin
      return clk_hz;
    end else begin
      return (clk_hz + (f_out / 2)) / f_out;
    end
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: period counter, active/pending divisor, registered
// clock output and period tick. Divisor changes only land at phase 0.
module clk_div_chan #(
  parameter int DIV_W   = 25,
  parameter int DEF_DIV = 27_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync,
  input  logic             wr_hit,
  input  logic [DIV_W-1:0] wr_div,
  output logic             clk_out,
  output logic             tick
);

  localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(DEF_DIV);
  localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_act_q, div_act_d;
  logic [DIV_W-1:0] div_pend_q, div_pend_d;
  logic [DIV_W-1:0] hi_start_s;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic             halt_s, wrap_s;

  // Next-state: the outputs are computed from the next count/divisor so the
  // registered clock and tick stay aligned with the registered counter.
  always_comb begin
    halt_s     = sync || !en;
    wrap_s     = en && (cnt_q == (div_act_q - ONE));
    div_pend_d = wr_hit ? wr_div : div_pend_q;
    if (halt_s || wrap_s) begin
      // Period boundary: a write in this same cycle is taken directly.
      div_act_d = div_pend_d;
      cnt_d     = '0;
    end else begin
      div_act_d = div_act_q;
      cnt_d     = cnt_q + ONE;
    end
    // Low phase is the longer half for odd divisors.
    hi_start_s = div_act_d - (div_act_d >> 1);
    if (halt_s) begin
      clk_out_d = 1'b0;
      tick_d    = 1'b0;
    end else begin
      clk_out_d = (cnt_d >= hi_start_s);
      tick_d    = (cnt_d == (div_act_d - ONE));
    end
  end

  // Channel state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q      <= '0;
      div_act_q  <= RST_DIV;
      div_pend_q <= RST_DIV;
      clk_out_q  <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      div_act_q  <= div_act_d;
      div_pend_q <= div_pend_d;
      clk_out_q  <= clk_out_d;
      tick_q     <= tick_d;
    end
  end

  assign clk_out = clk_out_q;
  assign tick    = tick_q;

endmodule

// File: rtl/clk_div_multi.sv
// N-channel programmable clock divider / tick generator. Decodes and
// validates divisor writes, flags rejected writes, and hosts the channels.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int DIV_W   = DIV_W_DEF,
  parameter int CLK_HZ  = CLK_HZ_DEF,
  parameter int DEF_DIV = hz2div(CLK_HZ, 1),
  parameter int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             CLK_IN,
  input  logic             rst,
  input  logic [N_CH-1:0]  en,
  input  logic             sync,
  input  logic             wr_en,
  input  logic [CH_W-1:0]  wr_ch,
  input  logic [DIV_W-1:0] wr_div,
  output logic             wr_err,
  output logic [N_CH-1:0]  CLK_OUT,
  output logic [N_CH-1:0]  tick
);

  logic            ch_oob_s;
  logic            div_bad_s;
  logic            wr_ok_s;
  logic [N_CH-1:0] wr_hit_s;
  logic            wr_err_q, wr_err_d;

  // Out-of-range channel numbers only exist when the select is wider than
  // the channel count needs.
  generate
    if ((2 ** CH_W) > N_CH) begin : g_oob
      assign ch_oob_s = ({1'b0, wr_ch} >= (CH_W + 1)'(N_CH));
    end else begin : g_no_oob
      assign ch_oob_s = 1'b0;
    end
  endgenerate

  // Write validity check and one-hot channel decode.
  always_comb begin
    div_bad_s = (wr_div < DIV_W'(MIN_DIV));
    wr_ok_s   = wr_en && !div_bad_s && !ch_oob_s;
    wr_err_d  = wr_en && (div_bad_s || ch_oob_s);
    wr_hit_s  = '0;
    for (int i = 0; i < N_CH; i++) begin
      wr_hit_s[i] = wr_ok_s && (wr_ch == CH_W'(i));
    end
  end

  // Rejected-write pulse register.
  always_ff @(posedge CLK_IN or negedge rst) begin
    if (!rst) begin
      wr_err_q <= 1'b0;
    end else begin
      wr_err_q <= wr_err_d;
    end
  end

  assign wr_err = wr_err_q;

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_chan
      clk_div_chan #(
        .DIV_W  (DIV_W),
        .DEF_DIV(DEF_DIV)
      ) u_chan (
        .clk    (CLK_IN),
        .rst    (rst),
        .en     (en[gi]),
        .sync   (sync),
        .wr_hit (wr_hit_s[gi]),
        .wr_div (wr_div),
        .clk_out(CLK_OUT[gi]),
        .tick   (tick[gi])
      );
    end
  endgenerate

endmodule
